cpu_core: RTL and testbench

- Single-cycle 18-bit load/store CPU; one instruction is fetched, decoded, executed and retired per clk.
- Contains PC, 16x18 register file, 1024x18 instruction memory, 1024x18 data memory and a combinational control unit.
- Top of the processor hierarchy. The bench preloads instruction memory and registers by hierarchical access.
- Debug outputs expose decode and control state.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_cu.sv | 56 +++++
 rtl/cpu_dmem.sv | 23 ++
 rtl/cpu_imem.sv | 25 ++
 rtl/cpu_regfile.sv | 31 +++
 rtl/cpu_core.sv | 122 ++++++++++++
 tb/tb_cpu_core.sv | 240 ++++++++++++++++++++++++
 7 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, instruction field positions, opcodes and the immediate sign-extender
// for the single-cycle 18-bit cpu_core.
package cpu_pkg;

  localparam int DATA_W     = 18;
  localparam int PC_W       = 10;
  localparam int REG_AW     = 4;
  localparam int NREGS      = 16;
  localparam int IMEM_DEPTH = 1024;
  localparam int DMEM_DEPTH = 1024;
  localparam int DADDR_W    = 10;
  localparam int IMM_W      = 6;

  localparam int OP_MSB = 17;
  localparam int OP_LSB = 14;
  localparam int RA_LSB = 10;
  localparam int RB_LSB = 6;
  localparam int RC_LSB = 2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_ORI  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XORI = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_JUMP = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic imm_sel;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext_imm6(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_cu.sv
// Combinational control unit. Opcode 1111 decodes as HALT only when CPU_HALT_EN
// is defined; otherwise it is a NOP.
module cpu_cu
  import cpu_pkg::*;
(
  input  logic       [3:0] opcode_i,
  input  logic             ra_eq_rb_i,
  input  logic             rst_n_i,
  input  logic             halted_i,
  output ctrl_t            ctrl_o,
  output logic             halt_o,
  output logic             pc_write_o,
  output logic             branch_o
);

  ctrl_t dec_s;
  logic  halt_s;
  logic  pc_write;
  logic  branch;

  // Opcode decode; writes are qualified by pc_write so reset/halt block all state change.
  always_comb begin
    dec_s  = '0;
    branch = 1'b0;
    halt_s = 1'b0;
    case (opcode_i)
      OP_ADD, OP_AND, OP_OR, OP_XOR: dec_s.reg_write = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_s.reg_write = 1'b1;
        dec_s.imm_sel   = 1'b1;
      end
      OP_LD:   dec_s.reg_write = 1'b1;
      OP_ST:   dec_s.mem_write = 1'b1;
      OP_JUMP: branch = 1'b1;
      OP_BEQ:  branch = ra_eq_rb_i;
      OP_BNE:  branch = ~ra_eq_rb_i;
      OP_HALT: begin
`ifdef CPU_HALT_EN
        halt_s = 1'b1;
`else
        halt_s = 1'b0;
`endif
      end
      default: dec_s = '0;
    endcase
    pc_write         = rst_n_i & ~halted_i & ~halt_s;
    ctrl_o           = dec_s;
    ctrl_o.reg_write = dec_s.reg_write & pc_write;
    ctrl_o.mem_write = dec_s.mem_write & pc_write;
  end

  assign halt_o     = halt_s;
  assign pc_write_o = pc_write;
  assign branch_o   = branch;

endmodule

// File: rtl/cpu_dmem.sv
// Data memory: asynchronous read, synchronous write, shared address.
module cpu_dmem
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] data_mem [DMEM_DEPTH];

  // Store port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = data_mem[addr_i];

endmodule

// File: rtl/cpu_imem.sv
// Instruction memory with asynchronous read; the write port exists for
// completeness and is tied off by the core (program is preloaded externally).
module cpu_imem
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PC_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PC_W-1:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] instr_mem [IMEM_DEPTH];

  // Optional synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      instr_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = instr_mem[raddr_i];

endmodule

// File: rtl/cpu_regfile.sv
// 16x18 register file: three asynchronous read ports (RB, RC, RA) and one
// synchronous write port. Not reset; contents are loaded externally.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [REG_AW-1:0] raddr_c_i,
  output logic [DATA_W-1:0] rdata_c_o,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o
);

  logic [DATA_W-1:0] registers [NREGS];

  // Write port; reads below see the pre-edge value of the destination.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  assign rdata_b_o = registers[raddr_b_i];
  assign rdata_c_o = registers[raddr_c_i];
  assign rdata_a_o = registers[raddr_a_i];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 18-bit load/store CPU top. Define CPU_HALT_EN to make opcode 1111
// a sticky HALT that only reset clears.
module cpu_core
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] debug_opcode,
  output logic       debug_pc_write,
  output logic       debug_branch
);

  logic [PC_W-1:0]   program_counter;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   pc_plus1_s;
  logic              halted_q;
  logic              halted_d;
  logic [DATA_W-1:0] current_instr;

  logic [3:0]         op_s;
  logic [REG_AW-1:0]  ra_s, rb_s, rc_s;
  logic [DADDR_W-1:0] addr_s;
  logic [DATA_W-1:0]  imm_s;
  logic [DATA_W-1:0]  rb_val_s, rc_val_s, ra_val_s;
  logic [DATA_W-1:0]  alu_b_s, wdata_s, dmem_rdata_s;

  ctrl_t ctrl_s;
  logic  halt_s, pc_write_s, branch_s;

  assign op_s   = current_instr[OP_MSB:OP_LSB];
  assign ra_s   = current_instr[RA_LSB +: REG_AW];
  assign rb_s   = current_instr[RB_LSB +: REG_AW];
  assign rc_s   = current_instr[RC_LSB +: REG_AW];
  assign addr_s = current_instr[DADDR_W-1:0];
  assign imm_s  = sext_imm6(current_instr[IMM_W-1:0]);

  cpu_imem my_instr_memory (
    .clk_i   (clk),
    .we_i    (1'b0),
    .waddr_i (10'd0),
    .wdata_i (18'd0),
    .raddr_i (program_counter),
    .rdata_o (current_instr)
  );

  cpu_regfile my_reg_file (
    .clk_i     (clk),
    .we_i      (ctrl_s.reg_write),
    .waddr_i   (ra_s),
    .wdata_i   (wdata_s),
    .raddr_b_i (rb_s),
    .rdata_b_o (rb_val_s),
    .raddr_c_i (rc_s),
    .rdata_c_o (rc_val_s),
    .raddr_a_i (ra_s),
    .rdata_a_o (ra_val_s)
  );

  cpu_dmem my_data_memory (
    .clk_i   (clk),
    .we_i    (ctrl_s.mem_write),
    .addr_i  (addr_s),
    .wdata_i (ra_val_s),
    .rdata_o (dmem_rdata_s)
  );

  cpu_cu my_cu (
    .opcode_i   (op_s),
    .ra_eq_rb_i (ra_val_s == rb_val_s),
    .rst_n_i    (reset),
    .halted_i   (halted_q),
    .ctrl_o     (ctrl_s),
    .halt_o     (halt_s),
    .pc_write_o (pc_write_s),
    .branch_o   (branch_s)
  );

  assign alu_b_s = ctrl_s.imm_sel ? imm_s : rc_val_s;

  // ALU / writeback select; modulo-2^18 arithmetic, no flags.
  always_comb begin
    case (op_s)
      OP_ADD, OP_ADDI: wdata_s = rb_val_s + alu_b_s;
      OP_AND, OP_ANDI: wdata_s = rb_val_s & alu_b_s;
      OP_OR,  OP_ORI:  wdata_s = rb_val_s | alu_b_s;
      OP_XOR, OP_XORI: wdata_s = rb_val_s ^ alu_b_s;
      OP_LD:           wdata_s = dmem_rdata_s;
      default:         wdata_s = 18'd0;
    endcase
  end

  // Next PC; all PC arithmetic wraps at 10 bits.
  always_comb begin
    pc_plus1_s = program_counter + 10'd1;
    if (!pc_write_s) begin
      pc_d = program_counter;
    end else if (branch_s && (op_s == OP_JUMP)) begin
      pc_d = addr_s;
    end else if (branch_s) begin
      pc_d = pc_plus1_s + imm_s[PC_W-1:0];
    end else begin
      pc_d = pc_plus1_s;
    end
    halted_d = halted_q | halt_s;
  end

  // PC and halt latch; reset clears both asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      program_counter <= 10'd0;
      halted_q        <= 1'b0;
    end else begin
      program_counter <= pc_d;
      halted_q        <= halted_d;
    end
  end

  assign debug_opcode   = op_s;
  assign debug_pc_write = pc_write_s;
  assign debug_branch   = branch_s;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed program plus random programs,
// compared against an instruction-level reference model.
module tb_cpu_core;

  logic       clk;
  logic       reset;
  logic [3:0] debug_opcode;
  logic       debug_pc_write;
  logic       debug_branch;

  cpu_core dut (
    .clk            (clk),
    .reset          (reset),
    .debug_opcode   (debug_opcode),
    .debug_pc_write (debug_pc_write),
    .debug_branch   (debug_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [17:0] imem_m [1024];
  logic [17:0] dmem_m [1024];
  logic [17:0] regs_m [16];
  int          pc_m;
  bit          halted_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put_instr(input int a, input logic [17:0] v);
    imem_m[a] = v;
    dut.my_instr_memory.instr_mem[a] = v;
  endtask

  task automatic put_data(input int a, input logic [17:0] v);
    dmem_m[a] = v;
    dut.my_data_memory.data_mem[a] = v;
  endtask

  task automatic put_reg(input int r, input logic [17:0] v);
    regs_m[r] = v;
    dut.my_reg_file.registers[r] = v;
  endtask

  function automatic logic [17:0] enc_rri(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [5:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [17:0] enc_ra(input logic [3:0] op, input logic [3:0] a,
                                         input logic [9:0] addr);
    return {op, a, addr};
  endfunction

  // Random word with opcodes 0..14 (HALT excluded so random runs keep going).
  function automatic logic [17:0] rand_instr();
    logic [3:0]  op;
    logic [13:0] rest;
    op   = 4'($urandom_range(0, 14));
    rest = 14'($urandom);
    return {op, rest};
  endfunction

  task automatic randomize_all();
    for (int i = 0; i < 1024; i++) begin
      put_instr(i, rand_instr());
      put_data(i, 18'($urandom));
    end
    for (int r = 0; r < 16; r++) put_reg(r, 18'($urandom));
  endtask

  // One instruction: check decode outputs, advance the model, clock, check state.
  task automatic run_step();
    logic [17:0] ins, immv;
    logic [3:0]  op, a, b, c;
    logic [9:0]  addr;
    int          imm, nxt;
    bit          eq, taken, halt_op, active;
    #1;
    ins  = imem_m[pc_m];
    op   = ins[17:14];
    a    = ins[13:10];
    b    = ins[9:6];
    c    = ins[5:2];
    addr = ins[9:0];
    imm  = int'(ins[5:0]);
    if (imm >= 32) imm = imm - 64;
    immv = 18'(imm);
    eq    = (regs_m[a] == regs_m[b]);
    taken = (op == 4'd10) || (op == 4'd11 && eq) || (op == 4'd12 && !eq);
`ifdef CPU_HALT_EN
    halt_op = (op == 4'd15);
`else
    halt_op = 1'b0;
`endif
    active = (reset === 1'b1) && !halted_m && !halt_op;
    check_val("dbg_opcode", debug_opcode, op);
    check_val("dbg_branch", debug_branch, taken);
    check_val("dbg_pc_write", debug_pc_write, active);
    nxt = (pc_m + 1) % 1024;
    if (active) begin
      case (op)
        4'd0:  regs_m[a] = regs_m[b] + regs_m[c];
        4'd1:  regs_m[a] = regs_m[b] & regs_m[c];
        4'd2:  regs_m[a] = regs_m[b] + immv;
        4'd3:  regs_m[a] = regs_m[b] & immv;
        4'd4:  regs_m[a] = regs_m[b] | regs_m[c];
        4'd5:  regs_m[a] = regs_m[b] | immv;
        4'd6:  regs_m[a] = regs_m[b] ^ regs_m[c];
        4'd7:  regs_m[a] = regs_m[b] ^ immv;
        4'd8:  regs_m[a] = dmem_m[addr];
        4'd9:  dmem_m[addr] = regs_m[a];
        4'd10: nxt = int'(addr);
        4'd11: if (eq) nxt = (pc_m + 1 + imm) & 1023;
        4'd12: if (!eq) nxt = (pc_m + 1 + imm) & 1023;
        default: ;
      endcase
      pc_m = nxt;
    end else if (halt_op && reset === 1'b1) begin
      halted_m = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val("pc", dut.program_counter, pc_m);
    for (int r = 0; r < 16; r++) begin
      check_val($sformatf("reg%0d", r), dut.my_reg_file.registers[r], regs_m[r]);
    end
    check_val("dmem", dut.my_data_memory.data_mem[addr], dmem_m[addr]);
    @(negedge clk);
  endtask

  logic [17:0] saved_d;

  initial begin
    reset    = 1'b1;
    pc_m     = 0;
    halted_m = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    randomize_all();
    #1;
    check_val("rst_pc", dut.program_counter, 32'd0);
    check_val("rst_opcode", debug_opcode, imem_m[0][17:14]);
    check_val("rst_pc_write", debug_pc_write, 32'd0);

    // Directed program
    put_instr(0, 18'h08004);                            // ADDI R0,R0,#4
    put_instr(1, 18'h24000);                            // ST R0,[0]
    put_instr(2, enc_rri(4'b0010, 4'd3, 4'd3, 6'h3F));  // ADDI R3,R3,#-1
    put_instr(3, enc_ra(4'b1010, 4'd0, 10'd5));         // JUMP 5
    put_instr(4, enc_ra(4'b1010, 4'd0, 10'd6));         // JUMP 6
    put_instr(5, enc_rri(4'b1011, 4'd1, 4'd2, 6'h3E));  // BEQ R1,R2,-2
    put_instr(6, enc_rri(4'b1100, 4'd1, 4'd2, 6'h3E));  // BNE R1,R2,-2
    put_instr(7, enc_ra(4'b1010, 4'd0, 10'd1023));      // JUMP 1023
    put_instr(1023, 18'h34000);                         // NOP
    put_reg(0, 18'd0);
    put_reg(1, 18'd7);
    put_reg(2, 18'd7);
    put_reg(3, 18'd0);
    run_step();                                         // edge while in reset
    reset = 1'b1;
    run_step();
    check_val("addi_r0", dut.my_reg_file.registers[0], 32'd4);
    check_val("addi_pc", dut.program_counter, 32'd1);
    run_step();
    check_val("st_dmem0", dut.my_data_memory.data_mem[0], 32'd4);
    run_step();
    check_val("addi_wrap", dut.my_reg_file.registers[3], 32'h3FFFF);
    run_step();
    run_step();
    check_val("beq_taken_pc", dut.program_counter, 32'd4);
    run_step();
    run_step();
    check_val("bne_not_taken_pc", dut.program_counter, 32'd7);
    run_step();
    check_val("jump_1023", dut.program_counter, 32'd1023);
    run_step();
    check_val("pc_wrap", dut.program_counter, 32'd0);
    for (int i = 0; i < 7; i++) run_step();
    check_val("second_pass_pc", dut.program_counter, 32'd7);

    // Reset mid-cycle at PC=7, with a store sitting at imem[0]
    reset = 1'b0;
    #1;
    check_val("midrst_pc", dut.program_counter, 32'd0);
    pc_m     = 0;
    halted_m = 1'b0;
    put_instr(0, enc_ra(4'b1001, 4'd4, 10'd9));         // ST R4,[9]
    saved_d = dmem_m[9];
    put_reg(4, saved_d ^ 18'h00001);
    for (int i = 0; i < 3; i++) run_step();
    check_val("midrst_no_store", dut.my_data_memory.data_mem[9], saved_d);
    reset = 1'b1;
    run_step();
    check_val("store_after_rst", dut.my_data_memory.data_mem[9], saved_d ^ 18'h00001);

    // Opcode 1111 at PC=2
    reset = 1'b0;
    pc_m     = 0;
    halted_m = 1'b0;
    put_instr(0, 18'h34000);
    put_instr(1, 18'h34000);
    put_instr(2, 18'h3C000);
    for (int i = 3; i < 8; i++) put_instr(i, 18'h38000);
    run_step();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) run_step();
`ifdef CPU_HALT_EN
    check_val("halt_pc", dut.program_counter, 32'd2);
    check_val("halt_pc_write", debug_pc_write, 32'd0);
`else
    check_val("nop15_pc", dut.program_counter, 32'd7);
    check_val("nop15_pc_write", debug_pc_write, 32'd1);
`endif

    // Random programs
    for (int pass = 0; pass < 2; pass++) begin
      reset    = 1'b0;
      pc_m     = 0;
      halted_m = 1'b0;
      randomize_all();
      run_step();
      reset = 1'b1;
      for (int i = 0; i < 200; i++) run_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
